rotary_input_conditioner: RTL and testbench

Upstream front-end for the primitive calculator's user inputs. It synchronises and debounces the rotary encoder A/B lines and the select and restart buttons. It decodes the quadrature into one-per-detent increment/decrement pulses and maintains a wrapping digit value (0..MAX_VALUE). The calculator core consumes the clean single-cycle pulses and the value instead of raw pad inputs.

---
 rtl/rotary_input_conditioner.sv | 193 +++++++++++++++++++
 tb/tb_rotary_input_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rotary_input_conditioner.sv
// Rotary encoder / button front-end: 2-flop sync, debounce, quadrature decode, wrapping value.
// Define ROTARY_ACCEL_EN to step by 2 on fast same-direction detents.
module rotary_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int VAL_W           = 4,
  parameter int MAX_VALUE       = 9,
  parameter int ACCEL_WINDOW    = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rotary_a,
  input  logic             rotary_b,
  input  logic             select,
  input  logic             restart,
  output logic             step_inc,
  output logic             step_dec,
  output logic [VAL_W-1:0] value,
  output logic             select_pulse,
  output logic             restart_pulse,
  output logic             quad_err
);

  localparam int NUM_IN = 4;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [VAL_W-1:0]  MAX_V   = VAL_W'(MAX_VALUE);
  localparam logic [NUM_IN-1:0] IDLE    = 4'b0011;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;

  if (DEBOUNCE_CYCLES < 2 || MAX_VALUE < 1 || MAX_VALUE >= 2**VAL_W || ACCEL_WINDOW < 1) begin : g_bad_cfg
    $error("rotary_input_conditioner: illegal parameter set");
  end

  // lane order {restart, select, a, b}, so lanes [1:0] read directly as AB
  logic [NUM_IN-1:0] raw;
  assign raw = {restart, select, rotary_a, rotary_b};

  logic [NUM_IN-1:0]            s1_q, s1_d, s2_q, s2_d, stb_q, stb_d, stb_prev_q, stb_prev_d;
  logic [NUM_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d       = raw;
    s2_d       = s1_q;
    stb_prev_d = stb_q;
    stb_d      = stb_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (s2_q[i] == stb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        stb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  logic              [1:0] cur_ab, prv_ab;
  logic                    cw;
  logic signed       [3:0] acc_q, acc_d, acc_nxt;
  logic                    step_inc_q, step_inc_d, step_dec_q, step_dec_d, quad_err_q, quad_err_d;
  logic                    select_pulse_q, select_pulse_d, restart_pulse_q, restart_pulse_d;

  assign cur_ab = stb_q[1:0];
  assign prv_ab = stb_prev_q[1:0];
  assign cw = (prv_ab == AB_11 && cur_ab == AB_10) || (prv_ab == AB_10 && cur_ab == AB_00) ||
              (prv_ab == AB_00 && cur_ab == AB_01) || (prv_ab == AB_01 && cur_ab == AB_11);

  // A detent only counts if the whole 4-step cycle ran one way; back at 11 the tally always clears.
  always_comb begin
    acc_d      = acc_q;
    acc_nxt    = acc_q;
    step_inc_d = 1'b0;
    step_dec_d = 1'b0;
    quad_err_d = 1'b0;
    if (cur_ab != prv_ab) begin
      if (cur_ab[0] != prv_ab[0] && cur_ab[1] != prv_ab[1]) begin
        acc_d      = '0;
        quad_err_d = 1'b1;
      end else begin
        acc_nxt = cw ? acc_q + 4'sd1 : acc_q - 4'sd1;
        if (cur_ab == AB_11) begin
          step_inc_d = (acc_nxt == 4'sd4);
          step_dec_d = (acc_nxt == -4'sd4);
          acc_d      = '0;
        end else begin
          acc_d = acc_nxt;
        end
      end
    end
    select_pulse_d  = stb_q[2] & ~stb_prev_q[2];
    restart_pulse_d = stb_q[3] & ~stb_prev_q[3];
  end

  logic fast;

`ifdef ROTARY_ACCEL_EN
  localparam int ACW = $clog2(ACCEL_WINDOW + 1);
  localparam logic [ACW-1:0] ACC_WIN = ACW'(ACCEL_WINDOW);

  logic [ACW-1:0] accel_cnt_q, accel_cnt_d;
  logic           dir_vld_q, dir_vld_d, dir_q, dir_d;

  always_comb begin
    accel_cnt_d = (accel_cnt_q == ACC_WIN) ? accel_cnt_q : accel_cnt_q + 1'b1;
    dir_vld_d   = dir_vld_q;
    dir_d       = dir_q;
    fast        = 1'b0;
    if (step_inc_d || step_dec_d) begin
      fast        = dir_vld_q && (dir_q == step_inc_d) && (accel_cnt_q < ACC_WIN);
      accel_cnt_d = '0;
      dir_vld_d   = 1'b1;
      dir_d       = step_inc_d;
    end
    if (restart_pulse_d) dir_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accel_cnt_q <= '0;
      dir_vld_q   <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      accel_cnt_q <= accel_cnt_d;
      dir_vld_q   <= dir_vld_d;
      dir_q       <= dir_d;
    end
  end
`else
  assign fast = 1'b0;
`endif

  logic [VAL_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (restart_pulse_d) begin
      value_d = '0;
    end else if (step_inc_d) begin
      if (fast)
        value_d = (value_q == MAX_V) ? VAL_W'(1) : (value_q == MAX_V - 1'b1) ? '0 : value_q + VAL_W'(2);
      else
        value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
    end else if (step_dec_d) begin
      if (fast)
        value_d = (value_q == '0) ? MAX_V - 1'b1 : (value_q == VAL_W'(1)) ? MAX_V : value_q - VAL_W'(2);
      else
        value_d = (value_q == '0) ? MAX_V : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q            <= IDLE;
      s2_q            <= IDLE;
      stb_q           <= IDLE;
      stb_prev_q      <= IDLE;
      cnt_q           <= '0;
      acc_q           <= '0;
      step_inc_q      <= 1'b0;
      step_dec_q      <= 1'b0;
      quad_err_q      <= 1'b0;
      select_pulse_q  <= 1'b0;
      restart_pulse_q <= 1'b0;
      value_q         <= '0;
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      stb_q           <= stb_d;
      stb_prev_q      <= stb_prev_d;
      cnt_q           <= cnt_d;
      acc_q           <= acc_d;
      step_inc_q      <= step_inc_d;
      step_dec_q      <= step_dec_d;
      quad_err_q      <= quad_err_d;
      select_pulse_q  <= select_pulse_d;
      restart_pulse_q <= restart_pulse_d;
      value_q         <= value_d;
    end
  end

  assign step_inc      = step_inc_q;
  assign step_dec      = step_dec_q;
  assign quad_err      = quad_err_q;
  assign select_pulse  = select_pulse_q;
  assign restart_pulse = restart_pulse_q;
  assign value         = value_q;

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// Scoreboard bench for rotary_input_conditioner: expected pulses are queued as stimulus is driven.
module tb_rotary_input_conditioner;
  localparam int D    = 4;
  localparam int MAXV = 9;
  localparam int AW   = 100;
  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       rst, ra, rb, sel, rs;
  logic       step_inc, step_dec, select_pulse, restart_pulse, quad_err;
  logic [3:0] value;

  rotary_input_conditioner #(.DEBOUNCE_CYCLES(D), .VAL_W(4), .MAX_VALUE(MAXV), .ACCEL_WINDOW(AW)) dut (
    .clk(clk), .rst(rst), .rotary_a(ra), .rotary_b(rb), .select(sel), .restart(rs),
    .step_inc(step_inc), .step_dec(step_dec), .value(value),
    .select_pulse(select_pulse), .restart_pulse(restart_pulse), .quad_err(quad_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse vector order {inc, dec, err, sel, restart}
  typedef struct { int cyc; logic [4:0] pul; int val; } exp_t;
  exp_t sb_q[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  int m_val = 0;
  bit m_dvld = 0, m_dir = 0;
  int m_last = 0;

  task automatic push(input int ecyc, input logic [4:0] pul);
    exp_t e;
    e.cyc = ecyc; e.pul = pul; e.val = m_val;
    sb_q.push_back(e);
  endtask

  task automatic push_step(input bit cw, input bit with_rs, input int ecyc);
    int amt;
    amt = 1;
`ifdef ROTARY_ACCEL_EN
    if (m_dvld && m_dir == cw && (ecyc - m_last - 1) < AW) amt = 2;
`endif
    m_val  = cw ? (m_val + amt) % (MAXV + 1) : (m_val + MAXV + 1 - amt) % (MAXV + 1);
    m_dvld = 1; m_dir = cw; m_last = ecyc;
    if (with_rs) begin m_val = 0; m_dvld = 0; end
    push(ecyc, {cw, ~cw, 1'b0, 1'b0, with_rs});
  endtask

  task automatic set_ab(input logic [1:0] ab, input int hold);
    @(negedge clk);
    ra = ab[1]; rb = ab[0];
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic detent(input bit cw, input bit with_rs);
    logic [1:0] seq [4];
    if (cw) seq = '{2'b10, 2'b00, 2'b01, 2'b11};
    else    seq = '{2'b01, 2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ra = seq[i][1]; rb = seq[i][0];
      if (i == 3) begin
        if (with_rs) rs = 1'b1;
        push_step(cw, with_rs, cyc + D + 3);
      end
      repeat (HOLD - 1) @(negedge clk);
    end
    rs = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [4:0] p;
    exp_t e;
    p = {step_inc, step_dec, quad_err, select_pulse, restart_pulse};
    if (p != 5'b0) begin
      chk("inc_dec_excl", 32'(step_inc & step_dec), 0);
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 32'(p), 0);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_kind", 32'(p), 32'(e.pul));
        chk("pulse_value", 32'(value), e.val);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit hit with %0d pulses outstanding", sb_q.size());
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ra = 1'b1; rb = 1'b1; sel = 1'b0; rs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_value", 32'(value), 0);
    chk("rst_pulses", 32'({step_inc, step_dec, quad_err, select_pulse, restart_pulse}), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_value", 32'(value), 0);

    // first detent, then nine more to wrap past MAX
    detent(1'b1, 1'b0);
    chk("cw1_value", 32'(value), m_val);
`ifndef ROTARY_ACCEL_EN
    chk("cw1_value_lit", 32'(value), 1);
`endif
    for (int k = 2; k <= 10; k++) begin
      detent(1'b1, 1'b0);
      chk("cwn_value", 32'(value), m_val);
`ifndef ROTARY_ACCEL_EN
      chk("cwn_value_lit", 32'(value), k % 10);
`endif
    end
    detent(1'b0, 1'b0);
    chk("ccw_value", 32'(value), m_val);
`ifndef ROTARY_ACCEL_EN
    chk("ccw_wrap_lit", 32'(value), MAXV);
`endif

    // reversal halfway: no pulse
    set_ab(2'b10, HOLD); set_ab(2'b00, HOLD); set_ab(2'b10, HOLD); set_ab(2'b11, HOLD);
    repeat (10) @(negedge clk);
    chk("reversal_value", 32'(value), m_val);

    // illegal jump 11->00, return via a legal partial path
    @(negedge clk);
    ra = 1'b0; rb = 1'b0;
    push(cyc + D + 3, 5'b00100);
    repeat (HOLD - 1) @(negedge clk);
    set_ab(2'b01, HOLD); set_ab(2'b11, HOLD);
    repeat (10) @(negedge clk);
    chk("jump_value", 32'(value), m_val);

    // select glitch then a real press
    @(negedge clk); sel = 1'b1;
    repeat (3) @(negedge clk); sel = 1'b0;
    repeat (20) @(negedge clk);
    sel = 1'b1;
    push(cyc + D + 3, 5'b00010);
    repeat (100) @(negedge clk);
    sel = 1'b0;
    repeat (30) @(negedge clk);

    // bring value down, then restart coinciding with a CW detent
    for (int k = 0; k < 4; k++) detent(1'b0, 1'b0);
`ifndef ROTARY_ACCEL_EN
    chk("pre_restart_lit", 32'(value), 5);
`endif
    detent(1'b1, 1'b1);
    chk("restart_value", 32'(value), 0);

    // reset in the middle of a detent
    set_ab(2'b10, HOLD); set_ab(2'b00, HOLD);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_value", 32'(value), 0);
    rst = 1'b0;
    m_val = 0; m_dvld = 0;
    push(cyc + D + 3, 5'b00100);
    repeat (HOLD - 1) @(negedge clk);
    set_ab(2'b01, HOLD); set_ab(2'b11, HOLD);
    repeat (20) @(negedge clk);
    chk("rst_mid_no_step", 32'(value), 0);

`ifdef ROTARY_ACCEL_EN
    detent(1'b0, 1'b0);
    repeat (150) @(negedge clk);
    detent(1'b0, 1'b0);
    repeat (150) @(negedge clk);
    chk("accel_start", 32'(value), 8);
    detent(1'b1, 1'b0);
    chk("accel_v1", 32'(value), 9);
    repeat (10) @(negedge clk);
    detent(1'b1, 1'b0);
    chk("accel_v2", 32'(value), 1);
    repeat (200) @(negedge clk);
    detent(1'b1, 1'b0);
    chk("accel_v3", 32'(value), 2);
    chk("accel_model", 32'(value), m_val);
`endif

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
